rsa_job_sequencer: RTL and testbench

RSA_JOB_SEQUENCER -- requirements
Module: rsa_job_sequencer

---
 rtl/rsa_pkg.sv | 20 ++
 rtl/rsa_seq_timer.sv | 33 +++
 rtl/rsa_job_sequencer.sv | 163 ++++++++++++++++
 tb/tb_rsa_job_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared constants for the RSA job sequencer: default parameters, counter
// widths and the FSM state encoding.
package rsa_pkg;

  localparam int unsigned WIDTH_DEF      = 8;
  localparam int unsigned CLR_CYCLES_DEF = 2;
  localparam int unsigned TIMEOUT_DEF    = 160;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned EXP_W = 9;
  localparam int unsigned ST_W  = 3;

  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_CLEAR   = 3'd1;
  localparam logic [ST_W-1:0] ST_RUN     = 3'd2;
  localparam logic [ST_W-1:0] ST_CAPTURE = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE    = 3'd4;
  localparam logic [ST_W-1:0] ST_ERROR   = 3'd5;

endpackage

// File: rtl/rsa_seq_timer.sv
// RUN-cycle counter for the job sequencer.
// Ports: clk, rstb (async active-low), clr (zero the count), en (count this
// cycle), count (saturating at all-ones), timeout_hit_c (count == TIMEOUT-1).
module rsa_seq_timer
  import rsa_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             timeout_hit_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT - 1);

  // Clear wins over counting; the count parks at its maximum.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign timeout_hit_c = (count == LIMIT);

endmodule

// File: rtl/rsa_job_sequencer.sv
// Job sequencer wrapping a modular-exponentiation core: shadows the job
// configuration, soft-resets the core, runs it with a timeout and captures
// the result.
// Ports: clk, rstb; job control start/abort/irq_ack; cfg_exp/cfg_plain/cfg_mod
// job operands; core_eoc/core_result from the core; core_en/core_rstb and
// shadowed core_exp/core_plain/core_mod to the core; status busy/done/
// err_timeout/irq; result and last_cycles of the last completed job.
module rsa_job_sequencer
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned CLR_CYCLES = CLR_CYCLES_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             abort,
  input  logic             irq_ack,
  input  logic [EXP_W-1:0] cfg_exp,
  input  logic [WIDTH-1:0] cfg_plain,
  input  logic [WIDTH-1:0] cfg_mod,
  input  logic             core_eoc,
  input  logic [WIDTH-1:0] core_result,
  output logic             core_en,
  output logic             core_rstb,
  output logic [EXP_W-1:0] core_exp,
  output logic [WIDTH-1:0] core_plain,
  output logic [WIDTH-1:0] core_mod,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic             irq,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] last_cycles
);

  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);

  logic [ST_W-1:0]  state, state_next;
  logic [CNT_W-1:0] clr_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic             timeout_hit_c;
  logic             accept_c, run_c, capture_c;
  logic             core_en_next, core_rstb_next, busy_next, done_next, err_next;

  assign accept_c  = (state == ST_IDLE) && start && !abort;
  assign run_c     = (state == ST_RUN);
  assign capture_c = run_c && core_eoc && !abort;

  rsa_seq_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk           (clk),
    .rstb          (rstb),
    .clr           (accept_c),
    .en            (run_c),
    .count         (run_cnt),
    .timeout_hit_c (timeout_hit_c)
  );

  // Next state, then decode of the state being entered so every status
  // output is registered and changes on the state-entry edge.
  always_comb begin
    state_next     = state;
    core_en_next   = 1'b0;
    core_rstb_next = 1'b0;
    busy_next      = 1'b0;
    done_next      = 1'b0;
    err_next       = 1'b0;

    case (state)
      ST_IDLE:    if (accept_c) state_next = ST_CLEAR;
      ST_CLEAR: begin
        if (abort)                   state_next = ST_IDLE;
        else if (clr_cnt == CLR_LAST) state_next = ST_RUN;
      end
      ST_RUN: begin
        // eoc has priority over a coincident timeout.
        if (abort)              state_next = ST_IDLE;
        else if (core_eoc)      state_next = ST_CAPTURE;
        else if (timeout_hit_c) state_next = ST_ERROR;
      end
      ST_CAPTURE: state_next = abort ? ST_IDLE : ST_DONE;
      ST_DONE:    if (irq_ack) state_next = ST_IDLE;
      ST_ERROR:   if (irq_ack) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase

    case (state_next)
      ST_CLEAR:   busy_next = 1'b1;
      ST_RUN: begin
        core_en_next   = 1'b1;
        core_rstb_next = 1'b1;
        busy_next      = 1'b1;
      end
      ST_CAPTURE: begin
        core_rstb_next = 1'b1;
        busy_next      = 1'b1;
      end
      ST_DONE:    done_next = 1'b1;
      ST_ERROR:   err_next  = 1'b1;
      default:    ;
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= ST_IDLE;
      core_en     <= 1'b0;
      core_rstb   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      irq         <= 1'b0;
    end else begin
      state       <= state_next;
      core_en     <= core_en_next;
      core_rstb   <= core_rstb_next;
      busy        <= busy_next;
      done        <= done_next;
      err_timeout <= err_next;
      irq         <= done_next | err_next;
    end
  end

  // CLEAR hold counter; restarts on every accepted job.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      clr_cnt <= '0;
    end else if (accept_c) begin
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + CNT_W'(1);
    end
  end

  // Shadowed job operands; the core never sees cfg_* directly.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      core_exp   <= '0;
      core_plain <= '0;
      core_mod   <= '0;
    end else if (accept_c) begin
      core_exp   <= cfg_exp;
      core_plain <= cfg_plain;
      core_mod   <= cfg_mod;
    end
  end

  // Result capture only on a successful end-of-computation in RUN.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      result      <= '0;
      last_cycles <= '0;
    end else if (capture_c) begin
      result      <= core_result;
      last_cycles <= run_cnt;
    end
  end

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Self-checking bench for rsa_job_sequencer: a table of jobs run through a
// core model, plus hand-written sequences for abort, ignored inputs and reset.
module tb_rsa_job_sequencer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         irq_ack = 1'b0;
  logic [8:0]   cfg_exp = '0;
  logic [W-1:0] cfg_plain = '0;
  logic [W-1:0] cfg_mod = '0;
  logic         core_eoc;
  logic [W-1:0] core_result = '0;
  logic         core_en, core_rstb;
  logic [8:0]   core_exp;
  logic [W-1:0] core_plain, core_mod;
  logic         busy, done, err_timeout, irq;
  logic [W-1:0] result;
  logic [7:0]   last_cycles;

  int passed = 0;
  int total  = 0;

  rsa_job_sequencer dut (
    .clk         (clk),
    .rstb        (rstb),
    .start       (start),
    .abort       (abort),
    .irq_ack     (irq_ack),
    .cfg_exp     (cfg_exp),
    .cfg_plain   (cfg_plain),
    .cfg_mod     (cfg_mod),
    .core_eoc    (core_eoc),
    .core_result (core_result),
    .core_en     (core_en),
    .core_rstb   (core_rstb),
    .core_exp    (core_exp),
    .core_plain  (core_plain),
    .core_mod    (core_mod),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .irq         (irq),
    .result      (result),
    .last_cycles (last_cycles)
  );

  always #5 clk = ~clk;

  // Core model: eoc pulses during RUN cycle index model_n (0-based from the
  // edge where core_en rose), i.e. model_n cycles after core_en rises.
  int   model_n = 999;
  int   k = 0;
  logic model_eoc = 1'b0;
  logic stray_eoc = 1'b0;
  assign core_eoc = model_eoc | stray_eoc;

  always @(negedge clk) begin
    if (core_en) begin
      model_eoc = (k == model_n);
      k = k + 1;
    end else begin
      model_eoc = 1'b0;
      k = 0;
    end
  end

  typedef struct {
    logic [8:0] exp;
    logic [7:0] plain;
    logic [7:0] mod;
    logic [7:0] res;
    int         n;
    int         abort_at;
    bit         disturb;
    int         exp_rc;
    bit         exp_done;
    bit         exp_err;
    logic [7:0] exp_result;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input vec_t v, input int idx);
    logic [7:0] prev_result;
    logic [7:0] prev_last;
    int clr;
    int rc;
    prev_result = result;
    prev_last   = last_cycles;
    model_n     = v.n;
    core_result = v.res;
    cfg_exp     = v.exp;
    cfg_plain   = v.plain;
    cfg_mod     = v.mod;
    start       = 1'b1;
    step();
    start = 1'b0;
    check($sformatf("v%0d busy_in_clear", idx), 32'(busy), 32'd1);
    check($sformatf("v%0d core_rstb_in_clear", idx), 32'(core_rstb), 32'd0);
    clr = 0;
    while (!core_en && clr < 10) begin
      step();
      clr++;
    end
    check($sformatf("v%0d clear_cycles", idx), 32'(clr), 32'd2);
    check($sformatf("v%0d core_rstb_run", idx), 32'(core_rstb), 32'd1);
    check($sformatf("v%0d core_exp", idx), 32'(core_exp), 32'(v.exp));
    check($sformatf("v%0d core_plain", idx), 32'(core_plain), 32'(v.plain));
    check($sformatf("v%0d core_mod", idx), 32'(core_mod), 32'(v.mod));
    // Changing cfg after acceptance must not reach the core.
    cfg_exp   = ~v.exp;
    cfg_plain = ~v.plain;
    cfg_mod   = ~v.mod;
    rc = 0;
    if (v.abort_at >= 0) begin
      repeat (v.abort_at) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      check($sformatf("v%0d abort_busy", idx), 32'(busy), 32'd0);
      check($sformatf("v%0d abort_core_en", idx), 32'(core_en), 32'd0);
      check($sformatf("v%0d abort_core_rstb", idx), 32'(core_rstb), 32'd0);
      check($sformatf("v%0d abort_irq", idx), 32'(irq), 32'd0);
      check($sformatf("v%0d abort_result", idx), 32'(result), 32'(prev_result));
      check($sformatf("v%0d abort_last", idx), 32'(last_cycles), 32'(prev_last));
      repeat (3) step();
      check($sformatf("v%0d abort_no_late_irq", idx), 32'(irq), 32'd0);
      return;
    end
    if (v.disturb) begin
      repeat (10) begin
        step();
        rc++;
      end
      start     = 1'b1;
      cfg_plain = 8'hFF;
      step();
      rc++;
      start = 1'b0;
      check($sformatf("v%0d disturb_core_plain", idx), 32'(core_plain), 32'(v.plain));
      check($sformatf("v%0d disturb_busy", idx), 32'(busy), 32'd1);
    end
    while (!irq && rc < 300) begin
      step();
      rc++;
    end
    check($sformatf("v%0d cycles_to_irq", idx), 32'(rc), 32'(v.exp_rc));
    check($sformatf("v%0d done", idx), 32'(done), 32'(v.exp_done));
    check($sformatf("v%0d err_timeout", idx), 32'(err_timeout), 32'(v.exp_err));
    check($sformatf("v%0d result", idx), 32'(result), 32'(v.exp_result));
    check($sformatf("v%0d last_cycles", idx), 32'(last_cycles), 32'(v.exp_last));
    check($sformatf("v%0d end_busy", idx), 32'(busy), 32'd0);
    check($sformatf("v%0d end_core_rstb", idx), 32'(core_rstb), 32'd0);
    // Abort and stray eoc are ignored once the job has ended.
    abort     = 1'b1;
    stray_eoc = 1'b1;
    step();
    abort     = 1'b0;
    stray_eoc = 1'b0;
    check($sformatf("v%0d irq_held", idx), 32'(irq), 32'd1);
    check($sformatf("v%0d result_held", idx), 32'(result), 32'(v.exp_result));
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check($sformatf("v%0d ack_irq", idx), 32'(irq), 32'd0);
    check($sformatf("v%0d ack_done", idx), 32'(done), 32'd0);
    check($sformatf("v%0d ack_err", idx), 32'(err_timeout), 32'd0);
  endtask

  initial begin
    int wait_en;
    //          exp     plain  mod    res    n    abort dist rc   done err  result last
    vecs[0] = '{9'h1AB, 8'h05, 8'h3B, 8'h2C, 133, -1,   0,   135, 1,   0,   8'h2C, 8'd133};
    vecs[1] = '{9'h0F0, 8'h12, 8'h3B, 8'h77, 999, -1,   0,   160, 0,   1,   8'h2C, 8'd133};
    vecs[2] = '{9'h003, 8'h07, 8'h3B, 8'h11, 100, 50,   0,   0,   0,   0,   8'h00, 8'd0};
    vecs[3] = '{9'h101, 8'h09, 8'h2F, 8'h5A, 20,  -1,   0,   22,  1,   0,   8'h5A, 8'd20};
    vecs[4] = '{9'h1AB, 8'h05, 8'h3B, 8'h9E, 159, -1,   1,   161, 1,   0,   8'h9E, 8'd159};
    vecs[5] = '{9'h000, 8'h00, 8'h01, 8'h01, 1,   -1,   0,   3,   1,   0,   8'h01, 8'd1};
    vecs[6] = '{9'h055, 8'h21, 8'h43, 8'h33, 5,   -1,   0,   7,   1,   0,   8'h33, 8'd5};

    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_core_en", 32'(core_en), 32'd0);
    check("reset_core_rstb", 32'(core_rstb), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_last", 32'(last_cycles), 32'd0);
    check("reset_core_exp", 32'(core_exp), 32'd0);
    rstb = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_job(vecs[i], i);

    // start together with abort in IDLE is ignored.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("idle_start_abort_busy", 32'(busy), 32'd0);

    // Stray eoc in IDLE changes nothing.
    core_result = 8'hE7;
    stray_eoc   = 1'b1;
    step();
    stray_eoc = 1'b0;
    check("idle_eoc_result", 32'(result), 32'h01);
    check("idle_eoc_irq", 32'(irq), 32'd0);

    // Abort during CLEAR returns to IDLE without irq.
    model_n = 999;
    start   = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("clear_abort_busy", 32'(busy), 32'd0);
    repeat (3) step();
    check("clear_abort_core_en", 32'(core_en), 32'd0);
    check("clear_abort_irq", 32'(irq), 32'd0);

    // Reset mid-RUN at cycle 70.
    model_n   = 999;
    cfg_plain = 8'h44;
    start     = 1'b1;
    step();
    start   = 1'b0;
    wait_en = 0;
    while (!core_en && wait_en < 10) begin
      step();
      wait_en++;
    end
    check("rst_job_entered_run", 32'(core_en), 32'd1);
    repeat (70) step();
    rstb = 1'b0;
    #1;
    check("rst_core_en", 32'(core_en), 32'd0);
    check("rst_core_rstb", 32'(core_rstb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_last", 32'(last_cycles), 32'd0);
    check("rst_core_plain", 32'(core_plain), 32'd0);
    @(posedge clk);
    #2;
    rstb = 1'b1;
    repeat (5) step();
    check("post_rst_irq", 32'(irq), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    run_job(vecs[6], 6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
